uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Packet-granular round-robin arbiter sharing one buffered UART transmitter between N byte-stream requesters. Each requester holds a grant for a whole message, delimited by `last`, or for at most MAXB bytes. The arbiter drives the transmitter's `write`/`data` inputs and throttles on its `busy` (buffer full) flag. It sits between the logging, debug and command sources on the system clock and the single shared TX pin.

## Interface
- N, 4: number of requesters, 2..8.
- HOLD, 3: write-low cycles after each write strobe before the next byte; minimum 3, covering busy synchronizer latency.
- MAXB, 0: maximum bytes per grant before forced rotation; 0 = unlimited.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request; byte valid on its `din` slice while high.
- last  in  N  marks the current byte as the final byte of the message.
- din  in  8N  byte per requester; requester i uses bits [8i+7:8i].
- ack  out  N  one-cycle pulse: requester's current byte consumed; requester advances `din`/`last` next cycle.
- gnt  out  N  one-hot grant, registered.
- write  out  1  transmitter write strobe, one cycle high per byte.
- data  out  8  byte to transmitter, registered; stable from one cycle before `write` rises through HOLD.
- busy  in  1  transmitter buffer-full flag; asynchronous, passed through a 2-flop synchronizer (`busy_s`).

## Operation
- FSM states: IDLE, LOAD, STROBE, HOLD.
- IDLE
  - If any `req` is set, pick the first set bit searching from ptr+1 upward, modulo N. Set `gnt` and go to LOAD. Reset byte counter `cnt`.
  - If no `req` is set, stay in IDLE.
- LOAD
  - If `req[g]`=0: abort, `ptr`<=g, go to IDLE. No byte is sent.
  - Else if `busy_s`=1: wait in LOAD.
  - Else: `data`<=din slice g, latch `last[g]`, `cnt`<=cnt+1, go to STROBE.
- STROBE: `write`=1 and `ack[g]`=1 for exactly this cycle, then go to HOLD.
- HOLD: `write`=0 for HOLD cycles via a down-counter. Then:
  - go to IDLE with `ptr`<=g and `gnt`<=0 if the latched `last`=1, or if MAXB≠0 and `cnt`==MAXB;
  - otherwise return to LOAD.
- Requests arriving while another requester holds the grant wait; there is no preemption.
- `req` falling during STROBE or HOLD has no effect on the byte in flight. It is seen at the next LOAD.
- Forced rotation at MAXB splits a message; this is acceptable and documented for users.
- `cnt` width is clog2(MAXB+1). `ptr` width is clog2(N).

## Timing
- Reset values: `gnt`=0, `ack`=0, `write`=0, `data`=8'h00, state IDLE, `ptr`=N-1 (requester 0 has first priority), synchronizer flops = 0.
- Reset mid-operation returns to IDLE on that edge and drops `write` immediately. A byte whose `write` had already risen is in the transmitter buffer and was already acked.
- Latency, with `req` sampled at edge 0 and `busy_s`=0:
  - `gnt` high after edge 0;
  - `data` valid after edge 1; `write` and `ack` high during cycle 1→2.
- Sustained rate: one byte per 2+HOLD cycles (5 with defaults).
- After release, `gnt` stays 0 for at least one cycle (IDLE) before the next grant.
- `busy` asserted by the transmitter reaches `busy_s` within 2 cycles. HOLD≥3 guarantees LOAD never samples a stale `busy_s` after the arbiter's own write.

## Structure
- Shared include `uart_tx_arb_defs.vh`: state encoding constants (ST_IDLE=0, ST_LOAD=1, ST_STROBE=2, ST_HOLD=3).
- One natural sub-module: `rr_pick`, a combinational round-robin selector. Inputs: `req[N]` and `ptr`. Outputs: one-hot `sel[N]` and index `idx`. It is reusable by other shared-peripheral arbiters.

## Test plan
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), busy=0:
  - exactly 3 `write` pulses, 5 cycles apart;
  - `data` sequence 0x41,0x42,0x43;
  - `gnt`=0001 throughout, then 0000.
- Requesters 1 and 2 both request 2-byte messages at the same cycle after reset:
  - requester 1 completes first, then requester 2;
  - no byte interleaving;
  - ≥1 cycle with `gnt`=0 between grants.
- `busy` held 1 for 20 cycles while requester 0 is granted: no `write` and no `ack` until 2 cycles after `busy` falls; then byte sent.
- MAXB=2, requester 0 sends a 5-byte message while requester 3 requests a 1-byte message: order is 0,0,3,0,0,0.
- Requester 2 drops `req` while in LOAD: no `write`, `gnt` clears next cycle, `ptr`=2. Then `rst` pulsed during HOLD: all outputs return to reset values on that edge.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and width helper.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [PW-1:0] idx
);

    always_comb begin
        int   k;
        logic found;
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        // i runs 1..N so ptr itself is searched last
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                sel[k] = 1'b1;
                idx    = PW'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter feeding one buffered UART transmitter from N byte streams.
// Handshake: a requester holds req high with a valid byte on its din/last slice; a one-cycle ack
// means that byte was taken, and the requester presents its next byte (or drops req) the cycle after.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int  N    = 4,
    parameter int  HOLD = 3,
    parameter int  MAXB = 0,
    localparam int PW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  last,
    input  logic [8*N-1:0] din,
    output logic [N-1:0]  ack,
    output logic [N-1:0]  gnt,
    output logic          write,
    output logic [7:0]    data,
    input  logic          busy,
    output state_t        dbg_state,
    output logic [PW-1:0] dbg_ptr
);

    localparam int CW = clog2_min1(MAXB + 1);
    localparam int HW = clog2_min1(HOLD);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          last_l;
    logic          busy_m;
    logic          busy_s;
    logic [N-1:0]  pick_sel;
    logic [PW-1:0] pick_idx;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .idx (pick_idx)
    );

    // busy comes from the transmitter's domain and is only trusted after two flops
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= busy;
            busy_s <= busy_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= PW'(N - 1);
            g      <= '0;
            gnt    <= '0;
            ack    <= '0;
            write  <= 1'b0;
            data   <= 8'h00;
            cnt    <= '0;
            hcnt   <= '0;
            last_l <= 1'b0;
        end else begin
            ack   <= '0;
            write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt   <= pick_sel;
                        g     <= pick_idx;
                        cnt   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!req[g]) begin
                        ptr   <= g;
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end else if (!busy_s) begin
                        data   <= din[{g, 3'b000} +: 8];
                        last_l <= last[g];
                        cnt    <= cnt + 1'b1;
                        write  <= 1'b1;
                        ack    <= gnt;
                        state  <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    hcnt  <= HW'(HOLD - 1);
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hcnt != '0) begin
                        hcnt <= hcnt - 1'b1;
                    end else if (last_l || (MAXB != 0 && cnt == CW'(MAXB))) begin
                        ptr   <= g;
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized message mixes on two configurations.
module tb_uart_tx_arb;
    import uart_tx_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [N-1:0]   req0, last0, req1, last1;
    logic [8*N-1:0] din0, din1;
    logic           busy0, busy1;
    logic [N-1:0]   ack0, gnt0, ack1, gnt1;
    logic           write0, write1;
    logic [7:0]     data0, data1;
    state_t         st0, st1;
    logic [1:0]     ptr0, ptr1;

    uart_tx_arb #(.N(N), .HOLD(3), .MAXB(0)) dut (
        .clk(clk), .rst(rst), .req(req0), .last(last0), .din(din0),
        .ack(ack0), .gnt(gnt0), .write(write0), .data(data0), .busy(busy0),
        .dbg_state(st0), .dbg_ptr(ptr0)
    );

    uart_tx_arb #(.N(N), .HOLD(3), .MAXB(2)) dut_m (
        .clk(clk), .rst(rst), .req(req1), .last(last1), .din(din1),
        .ack(ack1), .gnt(gnt1), .write(write1), .data(data1), .busy(busy1),
        .dbg_state(st1), .dbg_ptr(ptr1)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int tests_run = 0;
    int tests_failed = 0;

    logic [8:0] src_mem [2][N][64];
    int         src_hd [2][N];
    int         src_tl [2][N];
    int         m_ptr [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int exp_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic exp_push(input int d, input logic [W-1:0] v);
        if (d == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic exp_pop(input int d, output logic [W-1:0] v);
        if (d == 0) v = exp_q0.pop_front();
        else        v = exp_q1.pop_front();
    endtask

    function automatic logic [2:0] oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return 3'(i);
        return 3'd7;
    endfunction

    function automatic bit src_empty(input int d);
        for (int i = 0; i < N; i++) if (src_hd[d][i] != src_tl[d][i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_byte(input int d, input int r, input logic lst, input logic [7:0] b);
        if (src_hd[d][r] == src_tl[d][r]) begin
            src_hd[d][r] = 0;
            src_tl[d][r] = 0;
        end
        src_mem[d][r][src_tl[d][r]] = {lst, b};
        src_tl[d][r]++;
    endtask

    task automatic push_msg(input int d, input int r, input int len);
        for (int k = 0; k < len; k++)
            push_byte(d, r, (k == len - 1), 8'($urandom_range(0, 255)));
    endtask

    task automatic set_busy(input int d, input logic v);
        if (d == 0) busy0 = v;
        else        busy1 = v;
    endtask

    // Reference model: whole-message round robin over everything currently queued,
    // split after maxb bytes when a limit is configured.
    task automatic build_expected(input int d);
        int h [N];
        int p, k, n, maxb;
        logic [8:0] e;
        maxb = (d == 0) ? 0 : 2;
        p = m_ptr[d];
        for (int i = 0; i < N; i++) h[i] = src_hd[d][i];
        while (1) begin
            k = -1;
            for (int s = 1; s <= N; s++) begin
                if (k < 0 && h[(p + s) % N] < src_tl[d][(p + s) % N]) k = (p + s) % N;
            end
            if (k < 0) break;
            n = 0;
            while (1) begin
                e = src_mem[d][k][h[k]];
                h[k]++;
                n++;
                exp_push(d, {3'(k), e[7:0]});
                if (e[8] || (maxb != 0 && n == maxb) || h[k] >= src_tl[d][k]) break;
            end
            p = k;
        end
        m_ptr[d] = p;
    endtask

    task automatic wait_drain(input int d, input bit rnd_busy, input int budget);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            if (rnd_busy) set_busy(d, ($urandom_range(0, 5) == 0));
            tick();
            done = (exp_size(d) == 0) && src_empty(d) &&
                   (((d == 0) ? gnt0 : gnt1) == '0);
        end
        set_busy(d, 1'b0);
        repeat (3) tick();
        check($sformatf("drain_d%0d", d), 32'(done), 32'd1);
    endtask

    // ---------------- monitor + requester model ----------------
    logic [N-1:0]   prev_gnt [2];
    logic [N-1:0]   mon_g, mon_a, rv, lv;
    logic           mon_w;
    logic [7:0]     mon_dt;
    logic [W-1:0]   mon_e;
    logic [8*N-1:0] dv;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mon_g  = (d == 0) ? gnt0 : gnt1;
            mon_a  = (d == 0) ? ack0 : ack1;
            mon_w  = (d == 0) ? write0 : write1;
            mon_dt = (d == 0) ? data0 : data1;
            if (rst === 1'b0) begin
                if (mon_w === 1'b1) begin
                    if (exp_size(d) == 0) begin
                        check($sformatf("sb_depth_d%0d", d), 32'(exp_size(d)), 32'd1);
                    end else begin
                        exp_pop(d, mon_e);
                        check($sformatf("wr_byte_d%0d", d), 32'({oh_idx(mon_g), mon_dt}), 32'(mon_e));
                    end
                end
                if (mon_w === 1'b1 || mon_a != '0)
                    check($sformatf("ack_d%0d", d), 32'(mon_a), (mon_w === 1'b1) ? 32'(mon_g) : 32'd0);
                if (prev_gnt[d] != '0 && mon_g != prev_gnt[d])
                    check($sformatf("gnt_gap_d%0d", d), 32'(mon_g), 32'd0);
            end
            prev_gnt[d] = mon_g;
            rv = '0;
            lv = '0;
            dv = '0;
            for (int i = 0; i < N; i++) begin
                if (mon_a[i] === 1'b1 && src_hd[d][i] != src_tl[d][i]) src_hd[d][i]++;
                if (src_hd[d][i] != src_tl[d][i]) begin
                    rv[i] = 1'b1;
                    lv[i] = src_mem[d][i][src_hd[d][i]][8];
                    dv[8*i +: 8] = src_mem[d][i][src_hd[d][i]][7:0];
                end
            end
            if (d == 0) begin
                req0 = rv; last0 = lv; din0 = dv;
            end else begin
                req1 = rv; last1 = lv; din1 = dv;
            end
        end
    end

    // ---------------- test sequence ----------------
    int wt [8];
    int wr_n, bad, n;

    initial begin
        rst = 1'b1;
        busy0 = 1'b0;
        busy1 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = N - 1;
            for (int i = 0; i < N; i++) begin
                src_hd[d][i] = 0;
                src_tl[d][i] = 0;
            end
        end
        repeat (3) tick();
        check("rst_gnt", 32'(gnt0), 32'd0);
        check("rst_write", 32'(write0), 32'd0);
        check("rst_ack", 32'(ack0), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_state", 32'(st0), 32'(ST_IDLE));
        check("rst_ptr", 32'(ptr0), 32'd3);
        check("rst_ptr_m", 32'(ptr1), 32'd3);
        rst = 1'b0;
        tick();

        // Single requester, 3-byte message, latency and spacing
        push_byte(0, 0, 1'b0, 8'h41);
        push_byte(0, 0, 1'b0, 8'h42);
        push_byte(0, 0, 1'b1, 8'h43);
        build_expected(0);
        tick();
        check("lat_pre_gnt", 32'(gnt0), 32'd0);
        tick();
        check("lat_gnt", 32'(gnt0), 32'b0001);
        check("lat_gnt_nowr", 32'(write0), 32'd0);
        tick();
        check("lat_write", 32'(write0), 32'd1);
        check("lat_data", 32'(data0), 32'h41);
        wr_n = 1;
        wt[0] = 0;
        bad = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (write0 && wr_n < 8) begin
                wt[wr_n] = t;
                wr_n++;
            end
            if (wr_n < 3 && gnt0 != 4'b0001) bad++;
        end
        check("t1_nwrites", 32'(wr_n), 32'd3);
        check("t1_space01", 32'(wt[1] - wt[0]), 32'd5);
        check("t1_space12", 32'(wt[2] - wt[1]), 32'd5);
        check("t1_gnt_held", 32'(bad), 32'd0);
        check("t1_gnt_release", 32'(gnt0), 32'd0);

        // Two simultaneous 2-byte messages
        push_msg(0, 1, 2);
        push_msg(0, 2, 2);
        build_expected(0);
        wait_drain(0, 1'b0, 100);

        // busy throttling
        busy0 = 1'b1;
        repeat (3) tick();
        push_byte(0, 0, 1'b1, 8'h5a);
        build_expected(0);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (write0 || ack0 != '0) n++;
        end
        check("busy_no_write", 32'(n), 32'd0);
        busy0 = 1'b0;
        n = 0;
        for (int t = 1; t <= 10 && n == 0; t++) begin
            tick();
            if (write0) n = t;
        end
        check("busy_release_lat", 32'(n), 32'd3);
        wait_drain(0, 1'b0, 50);

        // Forced rotation with MAXB=2
        push_msg(1, 0, 5);
        push_msg(1, 3, 1);
        build_expected(1);
        wait_drain(1, 1'b0, 200);

        // Request withdrawn while waiting in LOAD
        busy0 = 1'b1;
        repeat (3) tick();
        push_byte(0, 2, 1'b1, 8'h77);
        for (int t = 0; t < 10 && gnt0 != 4'b0100; t++) tick();
        check("drop_gnt", 32'(gnt0), 32'b0100);
        repeat (2) tick();
        check("drop_in_load", 32'(st0), 32'(ST_LOAD));
        src_hd[0][2] = src_tl[0][2];
        tick();
        tick();
        check("drop_gnt_clr", 32'(gnt0), 32'd0);
        check("drop_nowrite", 32'(write0), 32'd0);
        check("drop_ptr", 32'(ptr0), 32'd2);
        m_ptr[0] = 2;
        busy0 = 1'b0;
        repeat (3) tick();
        push_msg(0, 0, 1);
        push_msg(0, 3, 1);
        build_expected(0);
        wait_drain(0, 1'b0, 100);

        // Reset pulsed while in HOLD
        push_msg(0, 1, 2);
        build_expected(0);
        for (int t = 0; t < 20 && !write0; t++) tick();
        check("rst_wr_seen", 32'(write0), 32'd1);
        tick();
        check("rst_in_hold", 32'(st0), 32'(ST_HOLD));
        rst = 1'b1;
        src_hd[0][1] = src_tl[0][1];
        exp_q0.delete();
        tick();
        check("mid_rst_gnt", 32'(gnt0), 32'd0);
        check("mid_rst_write", 32'(write0), 32'd0);
        check("mid_rst_ack", 32'(ack0), 32'd0);
        check("mid_rst_data", 32'(data0), 32'd0);
        check("mid_rst_state", 32'(st0), 32'(ST_IDLE));
        check("mid_rst_ptr", 32'(ptr0), 32'd3);
        rst = 1'b0;
        m_ptr[0] = N - 1;
        m_ptr[1] = N - 1;
        repeat (2) tick();

        // Randomized message mixes with random busy
        for (int round = 0; round < 8; round++) begin
            int d;
            d = round % 2;
            for (int r = 0; r < N; r++) begin
                int nm;
                nm = $urandom_range(0, 2);
                for (int m = 0; m < nm; m++) push_msg(d, r, $urandom_range(1, 4));
            end
            build_expected(d);
            wait_drain(d, 1'b1, 3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
